// File: rtl/system_sysid_monitor.sv
// Sequencing master that reads the sysid slave (ID, timestamp) and checks both words.
// Optional interrupt output enabled by defining SYSID_MONITOR_IRQ_EN.
module system_sysid_monitor #(
    parameter logic [31:0] EXPECTED_ID    = 32'h12345678,
    parameter logic [31:0] EXPECTED_TS    = 32'h548C83BC,
    parameter int unsigned RECHECK_CYCLES = 1024,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             clr_count,
    output logic             sysid_address,
    input  logic [31:0]      sysid_readdata,
    output logic             busy,
    output logic             done,
    output logic             id_ok,
    output logic             ts_ok,
    output logic             match,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [31:0]      id_value,
    output logic [31:0]      ts_value
`ifdef SYSID_MONITOR_IRQ_EN
    ,
    output logic             irq,
    input  logic             irq_ack
`endif
);

    localparam int unsigned WaitW = (RECHECK_CYCLES > 1) ? $clog2(RECHECK_CYCLES) : 1;
    localparam logic [WaitW-1:0] WaitLoad =
        WaitW'((RECHECK_CYCLES > 0) ? (RECHECK_CYCLES - 1) : 0);
    localparam bit OneShot = (RECHECK_CYCLES == 0);

    typedef enum logic [2:0] {StIdle, StRdId, StRdTs, StCmp, StWait} state_e;

    state_e             state_q, state_d;
    logic               addr_q, addr_d;
    logic               done_q, done_d;
    logic               id_ok_q, id_ok_d;
    logic               ts_ok_q, ts_ok_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
    logic [31:0]        id_q, id_d;
    logic [31:0]        ts_q, ts_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               id_eq, ts_eq;

    assign id_eq = (id_q == EXPECTED_ID);
    assign ts_eq = (ts_q == EXPECTED_TS);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        id_ok_d = id_ok_q;
        ts_ok_d = ts_ok_q;
        match_d = match_q;
        id_d    = id_q;
        ts_d    = ts_q;
        wait_d  = wait_q;
        // Clear takes effect before any increment on the same edge.
        cnt_base = clr_count ? '0 : cnt_q;
        cnt_d    = cnt_base;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRdId;
                    addr_d  = 1'b0;
                end
            end
            StRdId: begin
                id_d    = sysid_readdata;
                addr_d  = 1'b1;
                state_d = StRdTs;
            end
            StRdTs: begin
                ts_d    = sysid_readdata;
                addr_d  = 1'b0;
                state_d = StCmp;
            end
            StCmp: begin
                id_ok_d = id_eq;
                ts_ok_d = ts_eq;
                match_d = id_eq & ts_eq;
                done_d  = 1'b1;
                if (!(id_eq && ts_eq) && (cnt_base != '1)) begin
                    cnt_d = cnt_base + 1'b1;
                end
                if (OneShot) begin
                    state_d = StIdle;
                end else begin
                    state_d = StWait;
                    wait_d  = WaitLoad;
                end
            end
            StWait: begin
                if (start || (wait_q == '0)) begin
                    state_d = StRdId;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= 1'b0;
            done_q  <= 1'b0;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            id_q    <= '0;
            ts_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            id_ok_q <= id_ok_d;
            ts_ok_q <= ts_ok_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            wait_q  <= wait_d;
        end
    end

`ifdef SYSID_MONITOR_IRQ_EN
    logic irq_q, irq_d;

    // A mismatch on the same edge as an acknowledge keeps the interrupt raised.
    always_comb begin
        irq_d = irq_q;
        if (irq_ack) begin
            irq_d = 1'b0;
        end
        if ((state_q == StCmp) && !(id_eq && ts_eq)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    assign sysid_address  = addr_q;
    assign busy           = (state_q == StRdId) || (state_q == StRdTs) || (state_q == StCmp);
    assign done           = done_q;
    assign id_ok          = id_ok_q;
    assign ts_ok          = ts_ok_q;
    assign match          = match_q;
    assign mismatch_count = cnt_q;
    assign id_value       = id_q;
    assign ts_value       = ts_q;

endmodule

// File: tb/tb_system_sysid_monitor.sv
// Scoreboard bench: dut0 is one-shot with a 2-bit counter, dut1 rechecks every 4 wait cycles.
module tb_system_sysid_monitor;

    localparam logic [31:0] GOOD_ID = 32'h12345678;
    localparam logic [31:0] GOOD_TS = 32'h548C83BC;
    localparam logic [31:0] BAD_ID  = 32'hDEADBEEF;
    localparam logic [31:0] BAD_TS  = 32'h548C83BD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        rst0_n, start0, clr0, addr0, busy0, done0, id_ok0, ts_ok0, match0;
    logic        irq0, ack0;
    logic [1:0]  cnt0;
    logic [31:0] rdata0, idv0, tsv0, word_id0, word_ts0;

    logic        rst1_n, start1, clr1, addr1, busy1, done1, id_ok1, ts_ok1, match1;
    logic        irq1, ack1;
    logic [7:0]  cnt1;
    logic [31:0] rdata1, idv1, tsv1;

    assign rdata0 = addr0 ? word_ts0 : word_id0;
    assign rdata1 = addr1 ? GOOD_TS : GOOD_ID;

    system_sysid_monitor #(.RECHECK_CYCLES(0), .CNT_W(2)) u_dut0 (
        .clock(clk), .reset_n(rst0_n), .start(start0), .clr_count(clr0),
        .sysid_address(addr0), .sysid_readdata(rdata0), .busy(busy0), .done(done0),
        .id_ok(id_ok0), .ts_ok(ts_ok0), .match(match0), .mismatch_count(cnt0),
        .id_value(idv0), .ts_value(tsv0)
`ifdef SYSID_MONITOR_IRQ_EN
        , .irq(irq0), .irq_ack(ack0)
`endif
    );

    system_sysid_monitor #(.RECHECK_CYCLES(4)) u_dut1 (
        .clock(clk), .reset_n(rst1_n), .start(start1), .clr_count(clr1),
        .sysid_address(addr1), .sysid_readdata(rdata1), .busy(busy1), .done(done1),
        .id_ok(id_ok1), .ts_ok(ts_ok1), .match(match1), .mismatch_count(cnt1),
        .id_value(idv1), .ts_value(tsv1)
`ifdef SYSID_MONITOR_IRQ_EN
        , .irq(irq1), .irq_ack(ack1)
`endif
    );

`ifndef SYSID_MONITOR_IRQ_EN
    assign irq0 = 1'b0;
    assign irq1 = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        id_ok;
        logic        ts_ok;
        logic        match;
        logic [1:0]  cnt;
        logic [31:0] idv;
        logic [31:0] tsv;
    } exp0_t;

    exp0_t       q0[$];
    exp0_t       e0;
    int unsigned q1[$];

    task automatic push0(input logic idok, input logic tsok, input logic [1:0] c,
                         input logic [31:0] idv, input logic [31:0] tsv);
        exp0_t e;
        e.id_ok = idok;
        e.ts_ok = tsok;
        e.match = idok & tsok;
        e.cnt   = c;
        e.idv   = idv;
        e.tsv   = tsv;
        q0.push_back(e);
    endtask

    // dut0 monitor: every done pulse must consume one expected result.
    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_unexpected_done actual 1 required 0");
            end else begin
                e0 = q0.pop_front();
                chk("dut0_id_ok", id_ok0, e0.id_ok);
                chk("dut0_ts_ok", ts_ok0, e0.ts_ok);
                chk("dut0_match", match0, e0.match);
                chk("dut0_count", cnt0, e0.cnt);
                chk("dut0_id_value", idv0, e0.idv);
                chk("dut0_ts_value", tsv0, e0.tsv);
            end
        end
    end

    // dut1 monitor: done pulses must land on the expected cycles.
    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_done actual cycle %0d required none", cyc);
            end else begin
                chk("dut1_done_cycle", cyc, q1.pop_front());
                chk("dut1_match", match1, 1);
                chk("dut1_count", cnt1, 0);
            end
        end
    end

    // Called at a negedge; start sampled at edge k, returns at negedge after edge k+3.
    task automatic run0(input bit clr_at_cmp, input bit ack_at_cmp);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr0 = clr_at_cmp;
        ack0 = ack_at_cmp;
        @(negedge clk);
        clr0 = 1'b0;
        ack0 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int unsigned base;
        rst0_n = 1'b0; rst1_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        ack0 = 1'b0; ack1 = 1'b0;
        word_id0 = GOOD_ID; word_ts0 = GOOD_TS;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_addr", addr0, 0);
        chk("rst_match", match0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_irq", irq0, 0);
        rst0_n = 1'b1; rst1_n = 1'b1;
        @(negedge clk);

        // Basic pass with address and latency tracking.
        push0(1, 1, 0, GOOD_ID, GOOD_TS);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("basic_addr_rd_id", addr0, 0);
        chk("basic_busy", busy0, 1);
        @(negedge clk);
        chk("basic_addr_rd_ts", addr0, 1);
        chk("basic_id_captured", idv0, GOOD_ID);
        @(negedge clk);
        chk("basic_addr_cmp", addr0, 0);
        chk("basic_done_early", done0, 0);
        @(negedge clk);
        chk("basic_done", done0, 1);
        chk("basic_busy_idle", busy0, 0);
        @(negedge clk);
        chk("basic_done_one_cycle", done0, 0);
        chk("basic_match_held", match0, 1);

        // Timestamp mismatch.
        word_ts0 = BAD_TS;
        push0(1, 0, 1, GOOD_ID, BAD_TS);
        run0(0, 0);
        @(negedge clk);

        // Saturation with back-to-back checks, then clear coincident with a mismatch.
        word_id0 = BAD_ID; word_ts0 = GOOD_TS;
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        chk("clr_alone", cnt0, 0);
        for (int i = 0; i < 5; i++) begin
            push0(0, 1, (i < 3) ? 2'(i + 1) : 2'd3, BAD_ID, GOOD_TS);
            run0(0, 0);
        end
        push0(0, 1, 1, BAD_ID, GOOD_TS);
        run0(1, 0);
        @(negedge clk);

        // Reset while in RD_TS aborts the sequence.
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        rst0_n = 1'b0;
        @(negedge clk);
        rst0_n = 1'b1;
        chk("abort_count", cnt0, 0);
        chk("abort_id_value", idv0, 0);
        chk("abort_ts_ok", ts_ok0, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_addr", addr0, 0);
        chk("abort_irq", irq0, 0);
        repeat (6) @(negedge clk);
        chk("abort_idle", busy0, 0);

        // Start held into RD_ID must not queue a second check.
        push0(0, 1, 1, BAD_ID, GOOD_TS);
        start0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (8) @(negedge clk);

`ifdef SYSID_MONITOR_IRQ_EN
        chk("irq_set", irq0, 1);
        repeat (3) @(negedge clk);
        chk("irq_held", irq0, 1);
        ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
        chk("irq_acked", irq0, 0);
        push0(0, 1, 2, BAD_ID, GOOD_TS);
        run0(0, 1);
        chk("irq_set_wins", irq0, 1);
        ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
        word_id0 = GOOD_ID;
        push0(1, 1, 2, GOOD_ID, GOOD_TS);
        run0(0, 0);
        chk("irq_quiet_on_match", irq0, 0);
`endif
        @(negedge clk);

        // Periodic recheck on dut1, then a start during WAIT.
        base = cyc + 1;
        start1 = 1'b1;
        q1.push_back(base + 3);
        q1.push_back(base + 10);
        q1.push_back(base + 17);
        @(negedge clk);
        start1 = 1'b0;
        while (cyc < base + 18) @(negedge clk);
        chk("dut1_wait_not_busy", busy1, 0);
        q1.push_back(base + 22);
        q1.push_back(base + 29);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        while (cyc < base + 30) @(negedge clk);
        rst1_n = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1;
        repeat (3) @(negedge clk);

        chk("dut0_queue_drained", q0.size(), 0);
        chk("dut1_queue_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
